// File: rtl/bg_write_scheduler.sv
// Round-robin arbiter for the background tile RAM write port, with a built-in
// clear engine that sweeps the whole tile map to zero on command.
module bg_write_scheduler #(
  parameter int NUM_REQ    = 6,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int TILE_COUNT = 1200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_start,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      bg_wea,
  output logic [ADDR_W-1:0]         bg_ram_addr,
  output logic [DATA_W-1:0]         bg_ram_data,
  output logic [2:0]                grant_id,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      oob_flag
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] TILE_LAST = ADDR_W'(TILE_COUNT - 1);
  localparam logic [ADDR_W-1:0] TILE_END  = ADDR_W'(TILE_COUNT);
  localparam logic [2:0]        LAST_REQ  = 3'(NUM_REQ - 1);

  state_t              state_reg, state_next;
  logic [2:0]          ptr_reg, ptr_next;
  logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
  logic                wea_next, done_next, oob_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [DATA_W-1:0]   data_next;
  logic [2:0]          gid_next;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  in_range;

  logic                grant_found;
  logic [2:0]          grant_idx;
  int                  scan_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      assign in_range[gi] = (addr_arr[gi] <= TILE_LAST);
    end
  endgenerate

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = int'(ptr_reg) + off;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = 3'(scan_idx);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    clr_cnt_next = clr_cnt_reg;
    wea_next     = 1'b0;
    addr_next    = bg_ram_addr;
    data_next    = bg_ram_data;
    gid_next     = grant_id;
    done_next    = 1'b0;
    oob_next     = oob_flag;
    req_ready    = '0;
    case (state_reg)
      ST_ARB: begin
        if (clear_start) begin
          // The first sweep write (address 0) is issued straight from ARB.
          state_next   = ST_CLEAR;
          wea_next     = 1'b1;
          addr_next    = '0;
          data_next    = '0;
          clr_cnt_next = ADDR_W'(1);
        end else if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          gid_next             = grant_idx;
          ptr_next             = (grant_idx == LAST_REQ) ? 3'd0 : grant_idx + 3'd1;
          if (in_range[grant_idx]) begin
            wea_next  = 1'b1;
            addr_next = addr_arr[grant_idx];
            data_next = data_arr[grant_idx];
          end else begin
            oob_next = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_reg == TILE_END) begin
          state_next   = ST_ARB;
          done_next    = 1'b1;
          clr_cnt_next = '0;
        end else begin
          wea_next     = 1'b1;
          addr_next    = clr_cnt_reg;
          data_next    = '0;
          clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
        end
      end
      default: state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_ARB;
      ptr_reg     <= '0;
      clr_cnt_reg <= '0;
      bg_wea      <= 1'b0;
      bg_ram_addr <= '0;
      bg_ram_data <= '0;
      grant_id    <= '0;
      clear_done  <= 1'b0;
      oob_flag    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      clr_cnt_reg <= clr_cnt_next;
      bg_wea      <= wea_next;
      bg_ram_addr <= addr_next;
      bg_ram_data <= data_next;
      grant_id    <= gid_next;
      clear_done  <= done_next;
      oob_flag    <= oob_next;
    end
  end

  assign clear_busy = (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_bg_write_scheduler.sv
// Directed plus randomized bench for bg_write_scheduler against a small
// behavioural model of the round-robin and clear-sweep rules.
module tb_bg_write_scheduler;
  localparam int NR = 6;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TC = 1200;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear_start;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             bg_wea;
  logic [AW-1:0]    bg_ram_addr;
  logic [DW-1:0]    bg_ram_data;
  logic [2:0]       grant_id;
  logic             clear_busy;
  logic             clear_done;
  logic             oob_flag;

  int checks = 0;
  int errors = 0;

  // Model of architectural state: pointer and last registered outputs.
  int            m_ptr;
  int            m_gid;
  logic          m_wea;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_oob;

  bg_write_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TILE_COUNT(TC)) dut (
    .clk(clk), .reset(reset), .clear_start(clear_start),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .bg_wea(bg_wea), .bg_ram_addr(bg_ram_addr),
    .bg_ram_data(bg_ram_data), .grant_id(grant_id), .clear_busy(clear_busy),
    .clear_done(clear_done), .oob_flag(oob_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_gid = 0; m_wea = 1'b0; m_addr = '0; m_data = '0; m_oob = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear_start = 1'b0; req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_wea", bg_wea, 0);
    chk("rst_addr", bg_ram_addr, 0);
    chk("rst_data", bg_ram_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_oob", oob_flag, 0);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // One arbitration cycle with the inputs currently applied; acc = accepted index or -1.
  task automatic arb_cycle(output int acc);
    logic [NR-1:0] exp_ready;
    logic [AW-1:0] a;
    @(negedge clk); #1;
    acc = -1;
    exp_ready = '0;
    for (int off = 0; off < NR; off++) begin
      int idx;
      idx = (m_ptr + off) % NR;
      if (acc < 0 && req_valid[idx]) acc = idx;
    end
    if (acc >= 0) exp_ready[acc] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    @(posedge clk); #1;
    m_wea = 1'b0;
    if (acc >= 0) begin
      a = req_addr[acc*AW +: AW];
      m_ptr = (acc + 1) % NR;
      m_gid = acc;
      if (int'(a) < TC) begin
        m_wea = 1'b1; m_addr = a; m_data = req_data[acc*DW +: DW];
      end else begin
        m_oob = 1'b1;
      end
    end
    chk("wea", bg_wea, m_wea);
    chk("addr", bg_ram_addr, m_addr);
    chk("data", bg_ram_data, m_data);
    chk("grant_id", grant_id, m_gid);
    chk("oob", oob_flag, m_oob);
    chk("busy", clear_busy, 0);
    chk("done", clear_done, 0);
  endtask

  initial begin
    int acc;
    int bad;
    int wr_cnt [NR];
    logic [NR-1:0] pend;
    logic [AW-1:0] paddr [NR];
    logic [DW-1:0] pdata [NR];

    reset = 1'b1; clear_start = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    do_reset();

    // Idle
    repeat (10) arb_cycle(acc);

    // Single request from requester 2
    set_req(2, 16'd1085, 32'h1F0);
    req_valid = 6'b000100;
    arb_cycle(acc);
    chk("single_acc", acc, 2);
    chk("single_wea", bg_wea, 1);
    chk("single_addr", bg_ram_addr, 1085);
    chk("single_gid", grant_id, 2);
    req_valid = '0;

    // Round-robin under full load from reset
    do_reset();
    for (int i = 0; i < NR; i++) begin
      set_req(i, AW'(i * 100 + 5), DW'(32'hA0 + i));
      wr_cnt[i] = 0;
    end
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      arb_cycle(acc);
      chk("rr_order", acc, c % NR);
      if (acc >= 0 && bg_wea === 1'b1) wr_cnt[acc]++;
    end
    for (int i = 0; i < NR; i++) chk("rr_count", wr_cnt[i], 2);
    req_valid = '0;
    arb_cycle(acc);

    // Out-of-range request is accepted and dropped, flag is sticky
    set_req(4, 16'd1200, 32'hDEAD);
    req_valid = 6'b010000;
    arb_cycle(acc);
    chk("oob_acc", acc, 4);
    chk("oob_wea", bg_wea, 0);
    chk("oob_flag", oob_flag, 1);
    set_req(3, 16'd1199, 32'h33);
    req_valid = 6'b001000;
    arb_cycle(acc);
    chk("after_oob_wea", bg_wea, 1);
    chk("after_oob_addr", bg_ram_addr, 1199);
    chk("oob_held", oob_flag, 1);
    req_valid = '0;

    // Randomized traffic with hold-until-accepted requesters
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom % 2 == 1)) begin
          pend[i]  = 1'b1;
          paddr[i] = ($urandom % 16 == 0) ? AW'(TC + $urandom % 100) : AW'($urandom % TC);
          pdata[i] = $urandom;
        end
        set_req(i, paddr[i], pdata[i]);
      end
      req_valid = pend;
      arb_cycle(acc);
      if (acc >= 0) pend[acc] = 1'b0;
    end
    req_valid = '0;

    // Clear sweep with requester 1 pending and a second clear_start mid-sweep
    set_req(1, 16'd10, 32'h55);
    req_valid = 6'b000010;
    clear_start = 1'b1;
    @(negedge clk); #1;
    chk("clr_ready_start", req_ready, 0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    chk("clr_first_wea", bg_wea, 1);
    chk("clr_first_addr", bg_ram_addr, 0);
    chk("clr_first_data", bg_ram_data, 0);
    chk("clr_busy", clear_busy, 1);
    bad = 0;
    for (int k = 1; k < TC; k++) begin
      if (k == 300) clear_start = 1'b1;
      @(negedge clk); #1;
      if (req_ready !== '0) bad++;
      @(posedge clk); #1;
      clear_start = 1'b0;
      if (!(bg_wea === 1'b1 && bg_ram_addr === AW'(k) && bg_ram_data === '0 &&
            clear_busy === 1'b1 && clear_done === 1'b0)) bad++;
    end
    chk("clr_sweep_bad", bad, 0);
    @(negedge clk); #1;
    chk("clr_ready_last", req_ready, 0);
    @(posedge clk); #1;
    chk("clr_done", clear_done, 1);
    chk("clr_busy_end", clear_busy, 0);
    chk("clr_wea_end", bg_wea, 0);
    chk("clr_grant_ready", req_ready, 6'b000010);
    @(posedge clk); #1;
    req_valid = '0;
    chk("post_clr_wea", bg_wea, 1);
    chk("post_clr_addr", bg_ram_addr, 10);
    chk("post_clr_data", bg_ram_data, 32'h55);
    chk("post_clr_gid", grant_id, 1);
    chk("post_clr_done", clear_done, 0);
    m_ptr = 2; m_gid = 1; m_addr = 16'd10; m_data = 32'h55;
    arb_cycle(acc);

    // Reset in the middle of a sweep
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    for (int w = 0; w < 2000 && bg_ram_addr !== AW'(500); w++) begin
      @(posedge clk); #1;
    end
    chk("mid_addr", bg_ram_addr, 500);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("mid_busy", clear_busy, 0);
    chk("mid_wea", bg_wea, 0);
    chk("mid_done", clear_done, 0);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (clear_done !== 1'b0 || bg_wea !== 1'b0) bad++;
    end
    chk("mid_quiet", bad, 0);
    set_req(3, 16'd7, 32'h77);
    req_valid = 6'b001000;
    arb_cycle(acc);
    chk("mid_grant", acc, 3);
    req_valid = '0;
    arb_cycle(acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
